// File: rtl/scb_initiator.sv
// SCB bus initiator: accepts one read/write request at a time, runs it on the
// SCB bus with byte-lane steering and a wait-state timeout, then returns a
// one-cycle response carrying the error flag and the read data.
module scb_initiator #(
    parameter int A       = 11,
    parameter int TIMEOUT = 15
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         req_valid_i,
    output logic         req_ready_o,
    input  logic         req_wr_i,
    input  logic         req_byte_i,
    input  logic [A-1:0] req_addr_i,
    input  logic [15:0]  req_wdata_i,
    output logic         rsp_valid_o,
    output logic         rsp_err_o,
    output logic [15:0]  rsp_rdata_o,
    output logic [A-1:0] scb_Addr_o,
    output logic [15:0]  scb_Data_o,
    input  logic [15:0]  scb_Data_i,
    output logic [1:0]   scb_stb_o,
    output logic         scb_ce_o,
    output logic         scb_rd_o,
    output logic         scb_wr_o,
    input  logic         scb_rdy_i
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        RDATA,
        RESP
    } state_t;

    localparam logic [7:0] TIMEOUT_CNT = 8'(TIMEOUT);

    state_t     state;
    logic       lat_wr;
    logic       lat_byte;
    logic       lat_hi;
    logic [7:0] wait_cnt;

    // Word reads return the whole bus; byte reads pick the addressed lane
    // and zero-extend it into the low byte.
    function automatic logic [15:0] steer_rdata(input logic [15:0] bus,
                                                input logic        is_byte,
                                                input logic        hi_lane);
        if (!is_byte) begin
            return bus;
        end
        if (hi_lane) begin
            return {8'h00, bus[15:8]};
        end
        return {8'h00, bus[7:0]};
    endfunction

    // A new request can only be taken while nothing is in flight.
    assign req_ready_o = (state == IDLE);

    // Transaction sequencer: every bus and response output is registered here
    // so that they change only on clock edges (or on reset).
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state       <= IDLE;
            lat_wr      <= 1'b0;
            lat_byte    <= 1'b0;
            lat_hi      <= 1'b0;
            wait_cnt    <= 8'd0;
            scb_ce_o    <= 1'b0;
            scb_rd_o    <= 1'b0;
            scb_wr_o    <= 1'b0;
            scb_stb_o   <= 2'b00;
            scb_Addr_o  <= '0;
            scb_Data_o  <= 16'h0000;
            rsp_valid_o <= 1'b0;
            rsp_err_o   <= 1'b0;
            rsp_rdata_o <= 16'h0000;
        end else begin
            case (state)
                IDLE: begin
                    rsp_valid_o <= 1'b0;
                    if (req_valid_i) begin
                        lat_wr   <= req_wr_i;
                        lat_byte <= req_byte_i;
                        lat_hi   <= req_addr_i[0];
                        if (!req_byte_i && req_addr_i[0]) begin
                            // Misaligned word: answer with an error, no bus cycle.
                            state       <= RESP;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b1;
                            rsp_rdata_o <= 16'h0000;
                        end else begin
                            state    <= ACCESS;
                            wait_cnt <= 8'd0;
                            scb_ce_o <= 1'b1;
                            scb_rd_o <= ~req_wr_i;
                            scb_wr_o <= req_wr_i;
                            if (req_byte_i) begin
                                scb_stb_o  <= req_addr_i[0] ? 2'b10 : 2'b01;
                                scb_Addr_o <= req_addr_i;
                                scb_Data_o <= {req_wdata_i[7:0], req_wdata_i[7:0]};
                            end else begin
                                scb_stb_o  <= 2'b11;
                                scb_Addr_o <= {req_addr_i[A-1:1], 1'b0};
                                scb_Data_o <= req_wdata_i;
                            end
                        end
                    end
                end

                ACCESS: begin
                    if (scb_rdy_i) begin
                        if (lat_wr) begin
                            state       <= RESP;
                            scb_ce_o    <= 1'b0;
                            scb_wr_o    <= 1'b0;
                            scb_stb_o   <= 2'b00;
                            rsp_valid_o <= 1'b1;
                            rsp_err_o   <= 1'b0;
                            rsp_rdata_o <= 16'h0000;
                        end else begin
                            state    <= RDATA;
                            scb_rd_o <= 1'b0;
                        end
                    end else if (wait_cnt == TIMEOUT_CNT) begin
                        // Responder never answered: abort with an error.
                        state       <= RESP;
                        scb_ce_o    <= 1'b0;
                        scb_rd_o    <= 1'b0;
                        scb_wr_o    <= 1'b0;
                        scb_stb_o   <= 2'b00;
                        rsp_valid_o <= 1'b1;
                        rsp_err_o   <= 1'b1;
                        rsp_rdata_o <= 16'h0000;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end

                RDATA: begin
                    state       <= RESP;
                    scb_ce_o    <= 1'b0;
                    scb_stb_o   <= 2'b00;
                    rsp_valid_o <= 1'b1;
                    rsp_err_o   <= 1'b0;
                    rsp_rdata_o <= steer_rdata(scb_Data_i, lat_byte, lat_hi);
                end

                RESP: begin
                    state       <= IDLE;
                    rsp_valid_o <= 1'b0;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scb_initiator.sv
// Testbench for scb_initiator: directed requests against a cycle-indexed
// expectation table built from the bus protocol rules, plus literal checks
// on latency, chip-enable duration and returned data.
module tb_scb_initiator;

    localparam int TO = 15;

    logic        clk_i;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_ready_o;
    logic        req_wr_i;
    logic        req_byte_i;
    logic [10:0] req_addr_i;
    logic [15:0] req_wdata_i;
    logic        rsp_valid_o;
    logic        rsp_err_o;
    logic [15:0] rsp_rdata_o;
    logic [10:0] scb_Addr_o;
    logic [15:0] scb_Data_o;
    logic [15:0] scb_Data_i;
    logic [1:0]  scb_stb_o;
    logic        scb_ce_o;
    logic        scb_rd_o;
    logic        scb_wr_o;
    logic        scb_rdy_i;

    scb_initiator #(.A(11), .TIMEOUT(TO)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_valid_i(req_valid_i),
        .req_ready_o(req_ready_o),
        .req_wr_i   (req_wr_i),
        .req_byte_i (req_byte_i),
        .req_addr_i (req_addr_i),
        .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rsp_valid_o),
        .rsp_err_o  (rsp_err_o),
        .rsp_rdata_o(rsp_rdata_o),
        .scb_Addr_o (scb_Addr_o),
        .scb_Data_o (scb_Data_o),
        .scb_Data_i (scb_Data_i),
        .scb_stb_o  (scb_stb_o),
        .scb_ce_o   (scb_ce_o),
        .scb_rd_o   (scb_rd_o),
        .scb_wr_o   (scb_wr_o),
        .scb_rdy_i  (scb_rdy_i)
    );

    typedef struct packed {
        logic        ce;
        logic        rd;
        logic        wr;
        logic [1:0]  stb;
        logic [10:0] addr;
        logic [15:0] data;
        logic        rv;
        logic        err;
        logic [15:0] rdata;
    } exp_t;

    exp_t expq[int];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    int          obs_ce_total  = 0;
    int          obs_rsp_cyc   = -1;
    logic        obs_rsp_err   = 1'b0;
    logic [15:0] obs_rsp_rdata = 16'h0;
    logic [10:0] obs_cmd_addr  = '0;
    logic [15:0] obs_cmd_data  = '0;
    logic [1:0]  obs_cmd_stb   = '0;

    int t_hs;
    int ce_base;

    // Free-running clock, 10 time units per cycle.
    initial begin
        clk_i = 1'b0;
        forever #5 clk_i = ~clk_i;
    end

    // Cycle index: the cycle that starts at each rising edge.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s cycle=%0d actual=0x%0h expected=0x%0h", name, cyc, act, exp);
        end
    endtask

    // Expected behaviour of one request issued in cycle t. waits < 0 (or
    // beyond TO) means the responder never raises rdy.
    task automatic buildModel(input logic wr, input logic byt, input logic [10:0] addr,
                              input logic [15:0] wdata, input logic [15:0] rspdata,
                              input int waits, input int t,
                              output int end_c, output int rdy_c);
        exp_t        e;
        logic [1:0]  stb;
        logic [10:0] ba;
        logic [15:0] bd;
        bit          tmo;
        int          n;
        int          c;
        if (!byt && addr[0]) begin
            e       = '0;
            e.rv    = 1'b1;
            e.err   = 1'b1;
            expq[t + 1] = e;
            end_c   = t + 1;
            rdy_c   = -1;
        end else begin
            stb   = byt ? (addr[0] ? 2'b10 : 2'b01) : 2'b11;
            ba    = byt ? addr : (addr & ~11'h001);
            bd    = byt ? {wdata[7:0], wdata[7:0]} : wdata;
            tmo   = (waits < 0) || (waits > TO);
            n     = tmo ? TO + 1 : waits + 1;
            rdy_c = tmo ? -1 : t + 1 + waits;
            for (int k = 1; k <= n; k++) begin
                e      = '0;
                e.ce   = 1'b1;
                e.rd   = ~wr;
                e.wr   = wr;
                e.stb  = stb;
                e.addr = ba;
                e.data = bd;
                expq[t + k] = e;
            end
            c = t + n + 1;
            if (!wr && !tmo) begin
                e      = '0;
                e.ce   = 1'b1;
                e.stb  = stb;
                e.addr = ba;
                expq[c] = e;
                c++;
            end
            e     = '0;
            e.rv  = 1'b1;
            e.err = tmo;
            if (!tmo && !wr) begin
                e.rdata = byt ? {8'h00, (addr[0] ? rspdata[15:8] : rspdata[7:0])} : rspdata;
            end
            expq[c] = e;
            end_c   = c;
        end
    endtask

    // Issue one request and drive the responder until the response cycle.
    // While busy, junk is put on the request inputs; it must be ignored.
    task automatic applyStimulus(input logic wr, input logic byt, input logic [10:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] rspdata,
                                 input int waits);
        int end_c;
        int rdy_c;
        @(posedge clk_i);
        #1;
        t_hs        = cyc;
        ce_base     = obs_ce_total;
        req_valid_i = 1'b1;
        req_wr_i    = wr;
        req_byte_i  = byt;
        req_addr_i  = addr;
        req_wdata_i = wdata;
        scb_Data_i  = rspdata;
        scb_rdy_i   = 1'b0;
        buildModel(wr, byt, addr, wdata, rspdata, waits, t_hs, end_c, rdy_c);
        for (int c = t_hs + 1; c <= end_c; c++) begin
            @(posedge clk_i);
            #1;
            req_valid_i = (c < end_c);
            req_wr_i    = 1'($urandom);
            req_byte_i  = 1'($urandom);
            req_addr_i  = 11'($urandom);
            req_wdata_i = 16'($urandom);
            scb_rdy_i   = (c == rdy_c);
        end
        scb_rdy_i = 1'b0;
    endtask

    // Literal checks on the transaction just issued, taken once its response
    // cycle has been sampled.
    task automatic checkTxn(input int lat, input int ce_cycles, input logic err, input logic [15:0] rdata);
        @(negedge clk_i);
        #1;
        checkOutput("rsp_latency", obs_rsp_cyc - t_hs, lat);
        checkOutput("ce_cycles", obs_ce_total - ce_base, ce_cycles);
        checkOutput("rsp_err_lit", 32'(obs_rsp_err), 32'(err));
        checkOutput("rsp_rdata_lit", 32'(obs_rsp_rdata), 32'(rdata));
    endtask

    // Per-cycle comparison against the expectation table; cycles with no
    // entry must look idle with the last response values held.
    initial begin : compare
        exp_t        e;
        logic        m_err;
        logic [15:0] m_rdata;
        m_err   = 1'b0;
        m_rdata = 16'h0;
        forever begin
            @(negedge clk_i or posedge rst_i);
            if (rst_i) begin
                m_err   = 1'b0;
                m_rdata = 16'h0;
            end else if (!clk_i) begin
                e = expq.exists(cyc) ? expq[cyc] : '0;
                checkOutput("req_ready", 32'(req_ready_o), 32'(!expq.exists(cyc)));
                checkOutput("scb_ce", 32'(scb_ce_o), 32'(e.ce));
                checkOutput("scb_rd", 32'(scb_rd_o), 32'(e.rd));
                checkOutput("scb_wr", 32'(scb_wr_o), 32'(e.wr));
                checkOutput("scb_stb", 32'(scb_stb_o), 32'(e.stb));
                if (e.ce) checkOutput("scb_addr", 32'(scb_Addr_o), 32'(e.addr));
                if (e.ce && e.wr) checkOutput("scb_data", 32'(scb_Data_o), 32'(e.data));
                checkOutput("rsp_valid", 32'(rsp_valid_o), 32'(e.rv));
                if (e.rv) begin
                    m_err   = e.err;
                    m_rdata = e.rdata;
                end
                checkOutput("rsp_err", 32'(rsp_err_o), 32'(m_err));
                checkOutput("rsp_rdata", 32'(rsp_rdata_o), 32'(m_rdata));
                if (scb_ce_o) obs_ce_total++;
                if (scb_ce_o && (scb_rd_o || scb_wr_o)) begin
                    obs_cmd_addr = scb_Addr_o;
                    obs_cmd_data = scb_Data_o;
                    obs_cmd_stb  = scb_stb_o;
                end
                if (rsp_valid_o) begin
                    obs_rsp_cyc   = cyc;
                    obs_rsp_err   = rsp_err_o;
                    obs_rsp_rdata = rsp_rdata_o;
                end
            end
        end
    end

    // Hard time limit so the run always ends.
    initial begin : watchdog
        #100000;
        $display("[TB] FAIL watchdog time limit reached");
        $fatal(1, "[TB] time limit");
    end

    // Directed sequence.
    initial begin : stimulus
        int end_c;
        int rdy_c;
        rst_i       = 1'b0;
        req_valid_i = 1'b0;
        req_wr_i    = 1'b0;
        req_byte_i  = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        scb_Data_i  = '0;
        scb_rdy_i   = 1'b0;
        #1 rst_i = 1'b1;
        #1;
        checkOutput("reset_ready", 32'(req_ready_o), 32'd1);
        checkOutput("reset_ce", 32'(scb_ce_o), 32'd0);
        checkOutput("reset_stb", 32'(scb_stb_o), 32'd0);
        checkOutput("reset_addr", 32'(scb_Addr_o), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("reset_rdata", 32'(rsp_rdata_o), 32'd0);
        repeat (2) @(posedge clk_i);
        #3 rst_i = 1'b0;

        $display("[TB] word write 0x404");
        applyStimulus(1'b1, 1'b0, 11'h404, 16'hBEEF, 16'h0000, 0);
        checkTxn(2, 1, 1'b0, 16'h0000);
        checkOutput("ww_addr", 32'(obs_cmd_addr), 32'h404);
        checkOutput("ww_data", 32'(obs_cmd_data), 32'hBEEF);
        checkOutput("ww_stb", 32'(obs_cmd_stb), 32'h3);

        $display("[TB] byte read 0x405");
        applyStimulus(1'b0, 1'b1, 11'h405, 16'h0000, 16'h12AB, 0);
        checkTxn(3, 2, 1'b0, 16'h0012);
        checkOutput("br_addr", 32'(obs_cmd_addr), 32'h405);
        checkOutput("br_stb", 32'(obs_cmd_stb), 32'h2);

        $display("[TB] misaligned word read 0x007");
        applyStimulus(1'b0, 1'b0, 11'h007, 16'h0000, 16'hFFFF, 0);
        checkTxn(1, 0, 1'b1, 16'h0000);

        $display("[TB] word read with 3 wait states");
        applyStimulus(1'b0, 1'b0, 11'h100, 16'h0000, 16'hCAFE, 3);
        checkTxn(6, 5, 1'b0, 16'hCAFE);

        $display("[TB] timeout");
        applyStimulus(1'b0, 1'b0, 11'h200, 16'h0000, 16'h4444, -1);
        checkTxn(17, 16, 1'b1, 16'h0000);

        $display("[TB] odd byte write");
        applyStimulus(1'b1, 1'b1, 11'h033, 16'h125A, 16'h0000, 0);
        checkTxn(2, 1, 1'b0, 16'h0000);
        checkOutput("bw_data", 32'(obs_cmd_data), 32'h5A5A);
        checkOutput("bw_stb", 32'(obs_cmd_stb), 32'h2);

        $display("[TB] even byte read");
        applyStimulus(1'b0, 1'b1, 11'h000, 16'h0000, 16'h9876, 0);
        checkTxn(3, 2, 1'b0, 16'h0076);
        checkOutput("ber_stb", 32'(obs_cmd_stb), 32'h1);

        $display("[TB] rdy on the timeout cycle");
        applyStimulus(1'b1, 1'b0, 11'h7FE, 16'h0F0F, 16'h0000, TO);
        checkTxn(17, 16, 1'b0, 16'h0000);

        $display("[TB] rdy one cycle before timeout");
        applyStimulus(1'b0, 1'b1, 11'h001, 16'h0000, 16'hA55A, TO - 1);
        checkTxn(17, 16, 1'b0, 16'h00A5);

        $display("[TB] reset during access");
        @(posedge clk_i);
        #1;
        t_hs        = cyc;
        req_valid_i = 1'b1;
        req_wr_i    = 1'b0;
        req_byte_i  = 1'b0;
        req_addr_i  = 11'h300;
        scb_rdy_i   = 1'b0;
        buildModel(1'b0, 1'b0, 11'h300, 16'h0000, 16'h0000, -1, t_hs, end_c, rdy_c);
        @(posedge clk_i);
        #1 req_valid_i = 1'b0;
        @(posedge clk_i);
        #2;
        rst_i = 1'b1;
        expq.delete();
        #1;
        checkOutput("rst_mid_ce", 32'(scb_ce_o), 32'd0);
        checkOutput("rst_mid_rd", 32'(scb_rd_o), 32'd0);
        checkOutput("rst_mid_rsp_valid", 32'(rsp_valid_o), 32'd0);
        checkOutput("rst_mid_ready", 32'(req_ready_o), 32'd1);
        @(posedge clk_i);
        #3 rst_i = 1'b0;
        #1;
        checkOutput("post_rst_ready", 32'(req_ready_o), 32'd1);
        checkOutput("post_rst_err", 32'(rsp_err_o), 32'd0);

        $display("[TB] request after reset");
        applyStimulus(1'b0, 1'b0, 11'h02A, 16'h0000, 16'h1357, 1);
        checkTxn(4, 3, 1'b0, 16'h1357);

        repeat (3) @(posedge clk_i);
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/scb_initiator.md
SCB_INITIATOR -- requirements
Module: scb_initiator

Interface
REQ-001 Parameter: A, 11, SCB byte-address width.
REQ-002 Parameter: TIMEOUT, 15, maximum wait-state cycles before abort (1..255).
REQ-003 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-004 Ports:
- clk_i  in  1  clock.
- rst_i  in  1  async reset, active high.
- req_valid_i  in  1  request present.
- req_ready_o  out  1  request accepted when both this and req_valid_i are high.
- req_wr_i  in  1  1 = write, 0 = read.
- req_byte_i  in  1  1 = byte access, 0 = 16-bit word access.
- req_addr_i  in  A  byte address.
- req_wdata_i  in  16  write data; byte writes use bits [7:0].
- rsp_valid_o  out  1  one-cycle response pulse.
- rsp_err_o  out  1  response is an error; valid with rsp_valid_o.
- rsp_rdata_o  out  16  read data; valid with rsp_valid_o.
- scb_Addr_o  out  A  bus address.
- scb_Data_o  out  16  bus write data.
- scb_Data_i  in  16  bus read data.
- scb_stb_o  out  2  byte-lane strobes: [1] = odd/high byte, [0] = even/low byte.
- scb_ce_o  out  1  bus chip enable.
- scb_rd_o  out  1  read command.
- scb_wr_o  out  1  write command.
- scb_rdy_i  in  1  responder accepts the command this cycle.

Function
REQ-005 The block SHALL have 4 states: IDLE, ACCESS, RDATA, RESP. All bus outputs SHALL be registered.
REQ-006 IDLE:
- req_ready_o is 1 in IDLE only.
- On handshake, the block latches wr, byte, addr and wdata.
REQ-007 A misaligned request (word access with req_addr_i[0] = 1) SHALL go to RESP with err = 1 and rdata = 0; no bus cycle is issued.
REQ-008 Lane mapping:
- Word access: stb = 2'b11; scb_Addr_o = addr with bit 0 forced to 0.
- Byte access: stb = addr[0] ? 2'b10 : 2'b01.
- Byte write: scb_Data_o = {wdata[7:0], wdata[7:0]}.
- Word write: scb_Data_o = wdata.
REQ-009 ACCESS:
- scb_ce_o = 1, plus scb_rd_o or scb_wr_o per the request.
- Address, stb and data are held stable.
- scb_rdy_i is sampled each cycle.
REQ-010 In ACCESS with scb_rdy_i = 1: a write goes to RESP with err = 0; a read goes to RDATA.
REQ-011 RDATA (exactly 1 cycle):
- scb_ce_o stays 1; scb_rd_o = scb_wr_o = 0; address and stb are held.
- scb_Data_i is captured at the end of the cycle.
- Then the block goes to RESP.
REQ-012 Read data steering:
- Word: rsp_rdata_o = scb_Data_i.
- Byte: the selected lane (addr[0] ? [15:8] : [7:0]) is zero-extended into rsp_rdata_o[7:0].
REQ-013 Timeout:
- An 8-bit wait counter clears on entry to ACCESS and increments on each ACCESS cycle with scb_rdy_i = 0.
- When it equals TIMEOUT with scb_rdy_i still 0, the block goes to RESP with err = 1 and rdata = 0.
- scb_rdy_i = 1 in that same cycle takes priority over timeout.
REQ-014 RESP (exactly 1 cycle):
- rsp_valid_o = 1; bus outputs are deasserted (ce, rd, wr, stb = 0).
- Then the block returns to IDLE.
- rsp_err_o and rsp_rdata_o hold their values until the next response.
REQ-015 Latency from handshake cycle T, with zero wait states:
- Write: ce high at T+1; rsp_valid_o at T+2.
- Read: ce high at T+1 and T+2; rsp_valid_o at T+3.
- Each wait state adds one cycle.
REQ-016 The next request is accepted at the earliest in the cycle after rsp_valid_o.
REQ-017 req_valid_i and request fields SHALL be ignored outside IDLE.
REQ-018 Exactly one response SHALL be issued per accepted request.

Reset
REQ-019 On rst_i assertion (asynchronous, including mid-transaction):
- State = IDLE.
- scb_ce_o, scb_rd_o, scb_wr_o, scb_stb_o, scb_Addr_o, scb_Data_o = 0.
- rsp_valid_o, rsp_err_o, rsp_rdata_o = 0; wait counter = 0.
- req_ready_o = 1.
REQ-020 A transaction interrupted by reset SHALL produce no response.

Verification
REQ-021 Word write: addr 0x404, wdata 0xBEEF, rdy tied 1 -> at T+1 ce = 1, wr = 1, stb = 11, Addr = 0x404, Data = 0xBEEF; rsp_valid at T+2 with err = 0.
REQ-022 Byte read: addr 0x405, responder returns 0x12AB in RDATA -> stb = 10, Addr = 0x405; rsp_rdata = 0x0012 at T+3.
REQ-023 Misaligned word read: addr 0x007 -> no ce at any cycle; rsp_valid at T+1 with err = 1, rdata = 0.
REQ-024 Wait states: rdy low for 3 cycles, then high, on a word read -> ce held 4 cycles in ACCESS plus 1 in RDATA; rsp at T+6, err = 0.
REQ-025 Timeout: rdy never asserted, TIMEOUT = 15 -> ce high 16 cycles, then rsp with err = 1; ce low in the RESP cycle.
REQ-026 Reset mid-transaction: rst_i pulsed during ACCESS -> ce, rd, wr drop immediately; no rsp_valid; req_ready_o = 1 after reset; a following request completes normally.
